// File: rtl/matmul_addr_sequencer.sv
// Address sequencer for one C = A x B job: walks the i/j/k loop nest and issues
// one registered A/B/C byte-address triple per valid/ready beat.
module matmul_addr_sequencer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [DIM_W-1:0]  Rows,
    input  logic [DIM_W-1:0]  Inner,
    input  logic [DIM_W-1:0]  Cols,
    input  logic [ADDR_W-1:0] ABase,
    input  logic [ADDR_W-1:0] BBase,
    input  logic [ADDR_W-1:0] CBase,
    input  logic              Ready,
    output logic              Valid,
    output logic [ADDR_W-1:0] AAddr,
    output logic [ADDR_W-1:0] BAddr,
    output logic [ADDR_W-1:0] CAddr,
    output logic              Last,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [DIM_W-1:0] DimOne = DIM_W'(1);

    state_e state_q, state_d;

    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  inner_q, inner_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [ADDR_W-1:0] abase_q, abase_d;
    logic [ADDR_W-1:0] bbase_q, bbase_d;
    logic [ADDR_W-1:0] cbase_q, cbase_d;

    logic [DIM_W-1:0]  i_q, i_d;
    logic [DIM_W-1:0]  j_q, j_d;
    logic [DIM_W-1:0]  k_q, k_d;

    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic              last_q, last_d;

    logic              k_wrap;
    logic              j_wrap;
    logic              final_beat;

    // Row-major word offset (outer*stride + idx) scaled to bytes; operands zero-extended.
    function automatic logic [ADDR_W-1:0] byte_off(input logic [DIM_W-1:0] outer,
                                                  input logic [DIM_W-1:0] stride,
                                                  input logic [DIM_W-1:0] idx);
        logic [ADDR_W-1:0] word;
        word = ADDR_W'(outer) * ADDR_W'(stride) + ADDR_W'(idx);
        return word << 2;
    endfunction

    always_comb begin
        k_wrap     = (k_q == inner_q - DimOne);
        j_wrap     = k_wrap && (j_q == cols_q - DimOne);
        final_beat = j_wrap && (i_q == rows_q - DimOne);
    end

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        inner_d  = inner_q;
        cols_d   = cols_q;
        abase_d  = abase_q;
        bbase_d  = bbase_q;
        cbase_d  = cbase_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        c_addr_d = c_addr_q;
        last_d   = last_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    rows_d  = Rows;
                    inner_d = Inner;
                    cols_d  = Cols;
                    abase_d = ABase;
                    bbase_d = BBase;
                    cbase_d = CBase;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    if (Rows == '0 || Inner == '0 || Cols == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StRun;
                        // First beat is (0,0,0): every offset is zero.
                        a_addr_d = ABase;
                        b_addr_d = BBase;
                        c_addr_d = CBase;
                        last_d   = (Inner == DimOne);
                    end
                end
            end

            StRun: begin
                if (Ready) begin
                    if (final_beat) begin
                        state_d  = StDone;
                        i_d      = '0;
                        j_d      = '0;
                        k_d      = '0;
                        a_addr_d = '0;
                        b_addr_d = '0;
                        c_addr_d = '0;
                        last_d   = 1'b0;
                    end else begin
                        if (!k_wrap) begin
                            k_d = k_q + DimOne;
                        end else begin
                            k_d = '0;
                            if (!j_wrap) begin
                                j_d = j_q + DimOne;
                            end else begin
                                j_d = '0;
                                i_d = i_q + DimOne;
                            end
                        end
                        // Triple for the next beat is loaded with the counters.
                        a_addr_d = abase_q + byte_off(i_d, inner_q, k_d);
                        b_addr_d = bbase_q + byte_off(k_d, cols_q, j_d);
                        c_addr_d = cbase_q + byte_off(i_d, cols_q, j_d);
                        last_d   = (k_d == inner_q - DimOne);
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= StIdle;
            rows_q   <= '0;
            inner_q  <= '0;
            cols_q   <= '0;
            abase_q  <= '0;
            bbase_q  <= '0;
            cbase_q  <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rows_q   <= rows_d;
            inner_q  <= inner_d;
            cols_q   <= cols_d;
            abase_q  <= abase_d;
            bbase_q  <= bbase_d;
            cbase_q  <= cbase_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            c_addr_q <= c_addr_d;
            last_q   <= last_d;
        end
    end

    assign Valid = (state_q == StRun);
    assign Busy  = (state_q != StIdle);
    assign Done  = (state_q == StDone);
    assign Last  = last_q;
    assign AAddr = a_addr_q;
    assign BAddr = b_addr_q;
    assign CAddr = c_addr_q;

endmodule

// File: tb/tb_matmul_addr_sequencer.sv
// Bench for matmul_addr_sequencer: fixed 2x2x2 vector table, hand sequences for
// reset/start-while-busy, and randomized jobs checked against a loop-nest model.
module tb_matmul_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [4:0]  rows, inner, cols;
    logic [31:0] abase, bbase, cbase;
    logic        valid, last, busy, done;
    logic [31:0] aaddr, baddr, caddr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    matmul_addr_sequencer #(.ADDR_W(32), .DIM_W(5)) dut (
        .Clk   (clk),
        .Rst   (rst),
        .Start (start),
        .Rows  (rows),
        .Inner (inner),
        .Cols  (cols),
        .ABase (abase),
        .BBase (bbase),
        .CBase (cbase),
        .Ready (ready),
        .Valid (valid),
        .AAddr (aaddr),
        .BAddr (baddr),
        .CAddr (caddr),
        .Last  (last),
        .Busy  (busy),
        .Done  (done)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        l;
    } beat_t;

    beat_t expq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Reference: plain loop nest, k fastest, addresses from the row-major formulas.
    task automatic build_model(input int m, input int k, input int n,
                               input logic [31:0] ab, input logic [31:0] bb,
                               input logic [31:0] cb);
        beat_t t;
        expq.delete();
        if (m == 0 || k == 0 || n == 0) return;
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
                for (int kk = 0; kk < k; kk++) begin
                    t.a = ab + 32'(4 * (i * k + kk));
                    t.b = bb + 32'(4 * (kk * n + j));
                    t.c = cb + 32'(4 * (i * n + j));
                    t.l = (kk == k - 1);
                    expq.push_back(t);
                end
    endtask

    function automatic logic [99:0] beat_vec(input beat_t t);
        return {1'b1, t.l, 1'b1, 1'b0, t.a, t.b, t.c};
    endfunction

    function automatic logic [99:0] dut_vec();
        return {valid, last, busy, done, aaddr, baddr, caddr};
    endfunction

    // Launches a job in the current cycle; returns in the first IDLE cycle after Done.
    task automatic run_job(input int m, input int k, input int n,
                           input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] cb,
                           input int mode, input int poke_beat, input bit poke_done,
                           output int nbeats, output logic [31:0] first_a,
                           output logic [31:0] fifth_a, output logic [31:0] last_a,
                           output logic [31:0] last_c);
        int  budget;
        bit  finished;
        bit  poked;
        logic r;
        build_model(m, k, n, ab, bb, cb);
        budget   = expq.size() * 8 + 40;
        finished = 0;
        poked    = 0;
        nbeats   = 0;
        first_a  = '0;
        fifth_a  = '0;
        last_a   = '0;
        last_c   = '0;
        rows = 5'(m); inner = 5'(k); cols = 5'(n);
        abase = ab; bbase = bb; cbase = cb;
        start = 1'b1;
        tick();
        start = 1'b0;
        rows = 5'($urandom); inner = 5'($urandom); cols = 5'($urandom);
        abase = $urandom; bbase = $urandom; cbase = $urandom;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (expq.size() > 0) begin
                chk("beat", dut_vec(), beat_vec(expq[0]));
                case (mode)
                    0:       r = 1'b1;
                    1:       r = ((cyc % 3) == 0);
                    default: r = ($urandom_range(0, 3) != 0);
                endcase
                if (poke_beat >= 0 && nbeats == poke_beat && !poked) begin
                    poked = 1;
                    start = 1'b1;
                    rows = 5'($urandom_range(1, 4));
                    inner = 5'($urandom_range(1, 4));
                    cols = 5'($urandom_range(1, 4));
                end else begin
                    start = 1'b0;
                end
                ready = r;
                if (r) begin
                    if (nbeats == 0) first_a = aaddr;
                    if (nbeats == 4) fifth_a = aaddr;
                    last_a = aaddr;
                    last_c = caddr;
                    void'(expq.pop_front());
                    nbeats++;
                end
                tick();
                start = 1'b0;
            end else begin
                chk("done_cycle", {valid, last, busy, done}, 4'b0011);
                ready = 1'($urandom);
                start = poke_done;
                rows = 5'($urandom_range(1, 4));
                inner = 5'($urandom_range(1, 4));
                cols = 5'($urandom_range(1, 4));
                tick();
                start = 1'b0;
                chk("idle_after_done", {valid, last, busy, done}, 4'b0000);
                finished = 1;
                break;
            end
        end
        if (!finished) begin
            miscompares++;
            $display("FAIL job_timeout: got %0d beats pending, want 0", expq.size());
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        l;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int nb;
        logic [31:0] fa, f5, la, lc;

        tbl[0] = '{32'h100, 32'h200, 32'h300, 1'b0};
        tbl[1] = '{32'h104, 32'h208, 32'h300, 1'b1};
        tbl[2] = '{32'h100, 32'h204, 32'h304, 1'b0};
        tbl[3] = '{32'h104, 32'h20C, 32'h304, 1'b1};
        tbl[4] = '{32'h108, 32'h200, 32'h308, 1'b0};
        tbl[5] = '{32'h10C, 32'h208, 32'h308, 1'b1};
        tbl[6] = '{32'h108, 32'h204, 32'h30C, 1'b0};
        tbl[7] = '{32'h10C, 32'h20C, 32'h30C, 1'b1};

        rst = 1'b1; start = 1'b0; ready = 1'b0;
        rows = '0; inner = '0; cols = '0;
        abase = '0; bbase = '0; cbase = '0;
        tick();
        tick();
        chk("reset_state", dut_vec(), 100'd0);
        rst = 1'b0;
        tick();

        // Basic 2x2x2 against the fixed table.
        rows = 5'd2; inner = 5'd2; cols = 5'd2;
        abase = 32'h100; bbase = 32'h200; cbase = 32'h300;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        rows = 5'd7; inner = 5'd9; abase = 32'hDEAD_0000;
        for (int v = 0; v < 8; v++) begin
            chk("table_beat", dut_vec(), {1'b1, tbl[v].l, 1'b1, 1'b0, tbl[v].a, tbl[v].b, tbl[v].c});
            tick();
        end
        chk("table_done", {valid, last, busy, done}, 4'b0011);
        tick();
        chk("table_idle", {valid, last, busy, done}, 4'b0000);

        // Backpressure 1,0,0,... on the same job.
        run_job(2, 2, 2, 32'h100, 32'h200, 32'h300, 1, -1, 0, nb, fa, f5, la, lc);
        chk("bp_beats", 128'(nb), 128'd8);

        // Zero inner dimension and unit job.
        run_job(3, 0, 3, 32'h40, 32'h80, 32'hC0, 0, -1, 0, nb, fa, f5, la, lc);
        chk("zero_k_beats", 128'(nb), 128'd0);
        run_job(1, 1, 1, 32'h0, 32'h0, 32'h0, 0, -1, 0, nb, fa, f5, la, lc);
        chk("unit_beats", 128'(nb), 128'd1);

        // Start pulses at beat 3 and at Done are ignored; next-cycle Start launches.
        run_job(2, 2, 2, 32'h1000, 32'h2000, 32'h3000, 0, 2, 1, nb, fa, f5, la, lc);
        chk("busy_start_beats", 128'(nb), 128'd8);
        run_job(1, 2, 3, 32'h500, 32'h600, 32'h700, 2, -1, 0, nb, fa, f5, la, lc);
        chk("relaunch_beats", 128'(nb), 128'd6);

        // Reset while beat 5 is pending under backpressure.
        build_model(2, 2, 2, 32'h100, 32'h200, 32'h300);
        rows = 5'd2; inner = 5'd2; cols = 5'd2;
        abase = 32'h100; bbase = 32'h200; cbase = 32'h300;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("rst_pre_beat", dut_vec(), beat_vec(expq[0]));
            void'(expq.pop_front());
            tick();
        end
        chk("rst_beat5", dut_vec(), beat_vec(expq[0]));
        ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_outputs", dut_vec(), 100'd0);
        ready = 1'b1;
        tick();
        chk("rst_no_done", dut_vec(), 100'd0);
        run_job(2, 2, 2, 32'h100, 32'h200, 32'h300, 0, -1, 0, nb, fa, f5, la, lc);
        chk("rst_restart_beats", 128'(nb), 128'd8);

        // Randomized small jobs with random backpressure and stray Start pulses.
        for (int t = 0; t < 25; t++) begin
            run_job(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 5)), $urandom, $urandom, $urandom,
                    2, int'($urandom_range(0, 5)) - 1, 1'($urandom), nb, fa, f5, la, lc);
        end

        // Maximum dims with A base wrapping.
        run_job(31, 31, 31, 32'hFFFF_FFF0, 32'h0001_0000, 32'h0002_0000, 0, -1, 0,
                nb, fa, f5, la, lc);
        chk("max_beats", 128'(nb), 128'd29791);
        chk("max_first_a", 128'(fa), 128'hFFFF_FFF0);
        chk("max_fifth_a", 128'(f5), 128'h0000_0000);
        chk("max_last_a", 128'(la), 128'h0000_0EF0);
        chk("max_last_c", 128'(lc), 128'h0002_0F00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
